// File: rtl/led_pkg.sv
// Shared definitions for the LED PWM bank: mode codes, board polarity map, sizing helper.
// Latency: none, constants and a constant function only.
// Backpressure: not applicable.
package led_pkg;

    // Channel mode encoding as written on WR_MODE
    localparam logic [1:0] LED_OFF     = 2'd0;
    localparam logic [1:0] LED_ON      = 2'd1;
    localparam logic [1:0] LED_PWM     = 2'd2;
    localparam logic [1:0] LED_BREATHE = 2'd3;

    // iCEBreaker map: ch0=LEDR_N, ch1=LEDG_N are active-low, ch2..6 (PMOD LED1..LED5) active-high
    localparam int         LED_N_CH_DEF     = 7;
    localparam logic [6:0] LED_INV_MASK_DEF = 7'b0000011;

    // Ceiling log2 with a floor of 1 so that a single-entry range still gets a 1-bit field
    function automatic int led_clog2(input int value);
        int width;
        width = 1;
        while ((1 << width) < value) begin
            width = width + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/led_pwm_timebase.sv
// Shared PWM timebase: prescaler, frame counter, frame strobe and breathe level (gamma-mapped under LED_GAMMA_EN).
// Latency: fb is combinational from cnt; frame_stb and level update on the CLK edge that ends a frame.
// Backpressure: none, free-running.
module led_pwm_timebase
    import led_pkg::*;
#(
    parameter int PWM_BITS = 8,
    parameter int PRESCALE = 47
) (
    input  logic                CLK,
    input  logic                RST,
    output logic [PWM_BITS-1:0] cnt,
    output logic                fb,
    output logic                frame_stb,
    output logic [PWM_BITS-1:0] level
);

    localparam int                  PW       = led_clog2(PRESCALE);
    localparam logic [PW-1:0]       PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [PWM_BITS-1:0] CNT_MAX  = '1;

    logic [PW-1:0]       pre_cnt;
    logic                tick;
    logic [PWM_BITS-1:0] lvl;
    logic [PWM_BITS-1:0] lvl_nxt;
    logic                dir_up;
    logic                dir_up_nxt;

    assign tick = (pre_cnt == PRE_LAST);
    assign fb   = tick && (cnt == CNT_MAX);

    // Prescaler: divides CLK down to PWM ticks
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    // PWM position within the frame, wraps naturally at 2^PWM_BITS
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Frame strobe lands on the first cycle of the new frame (cnt==0)
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            frame_stb <= 1'b0;
        end else begin
            frame_stb <= fb;
        end
    end

    // Breathe triangle: the turning frame repeats the end value, giving a 2*2^PWM_BITS frame period
    always_comb begin
        lvl_nxt    = lvl;
        dir_up_nxt = dir_up;
        if (dir_up) begin
            if (lvl == CNT_MAX) begin
                dir_up_nxt = 1'b0;
            end else begin
                lvl_nxt = lvl + 1'b1;
            end
        end else begin
            if (lvl == '0) begin
                dir_up_nxt = 1'b1;
            end else begin
                lvl_nxt = lvl - 1'b1;
            end
        end
    end

    // Breathe state only moves at frame boundaries so a frame never sees two levels
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lvl    <= '0;
            dir_up <= 1'b1;
        end else if (fb) begin
            lvl    <= lvl_nxt;
            dir_up <= dir_up_nxt;
        end
    end

`ifdef LED_GAMMA_EN
    logic [PWM_BITS-1:0] lvl_eff;

    function automatic logic [PWM_BITS-1:0] gamma_map(input logic [PWM_BITS-1:0] v);
        logic [2*PWM_BITS-1:0] sq;
        sq = (2*PWM_BITS)'(v) * (2*PWM_BITS)'(v);
        return sq[2*PWM_BITS-1:PWM_BITS];
    endfunction

    // Square the upcoming level once per frame so the compare path sees a plain register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lvl_eff <= '0;
        end else if (fb) begin
            lvl_eff <= gamma_map(lvl_nxt);
        end
    end

    assign level = lvl_eff;
`else
    assign level = lvl;
`endif

endmodule

// File: rtl/led_pwm_bank.sv
// Multi-channel LED driver: per-channel OFF/ON/PWM/breathe with shadowed config and per-pin polarity; LED_GAMMA_EN squares duty/level.
// Latency: a write takes effect at the next frame start; cnt to LED pin is 1 CLK.
// Backpressure: none, WR_EN is accepted every cycle; out-of-range WR_ADDR is dropped.
module led_pwm_bank
    import led_pkg::*;
#(
    parameter int              N_CH     = LED_N_CH_DEF,
    parameter int              PWM_BITS = 8,
    parameter int              PRESCALE = 47,
    parameter logic [N_CH-1:0] INV_MASK = N_CH'(LED_INV_MASK_DEF)
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        WR_EN,
    input  logic [led_clog2(N_CH)-1:0]  WR_ADDR,
    input  logic [1:0]                  WR_MODE,
    input  logic [PWM_BITS-1:0]         WR_DUTY,
    output logic [N_CH-1:0]             LED,
    output logic                        FRAME_STB
);

    localparam int AW = led_clog2(N_CH);

    logic [PWM_BITS-1:0] cnt;
    logic [PWM_BITS-1:0] level;
    logic                fb;
    logic                wr_ok;
    logic [N_CH-1:0]     on;

    led_pwm_timebase #(
        .PWM_BITS (PWM_BITS),
        .PRESCALE (PRESCALE)
    ) u_timebase (
        .CLK       (CLK),
        .RST       (RST),
        .cnt       (cnt),
        .fb        (fb),
        .frame_stb (FRAME_STB),
        .level     (level)
    );

    assign wr_ok = WR_EN && ({1'b0, WR_ADDR} < (AW + 1)'(N_CH));

`ifdef LED_GAMMA_EN
    function automatic logic [PWM_BITS-1:0] gamma_map(input logic [PWM_BITS-1:0] v);
        logic [2*PWM_BITS-1:0] sq;
        sq = (2*PWM_BITS)'(v) * (2*PWM_BITS)'(v);
        return sq[2*PWM_BITS-1:PWM_BITS];
    endfunction
`endif

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        localparam logic [AW-1:0] CH_ADDR = AW'(g);

        logic                hit;
        logic [1:0]          pend_mode;
        logic [PWM_BITS-1:0] pend_duty;
        logic [1:0]          new_mode;
        logic [PWM_BITS-1:0] new_duty;
        logic [PWM_BITS-1:0] new_eff;
        logic [1:0]          act_mode;
        logic [PWM_BITS-1:0] act_duty;
        logic                ch_on;

        assign hit = wr_ok && (WR_ADDR == CH_ADDR);

        // A write landing in the boundary cycle bypasses pending so it rules the very next frame
        assign new_mode = hit ? WR_MODE : pend_mode;
        assign new_duty = hit ? WR_DUTY : pend_duty;

`ifdef LED_GAMMA_EN
        assign new_eff = gamma_map(new_duty);
`else
        assign new_eff = new_duty;
`endif

        // Pending copy: absorbs writes at any time without touching the running waveform
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                pend_mode <= LED_OFF;
                pend_duty <= '0;
            end else if (hit) begin
                pend_mode <= WR_MODE;
                pend_duty <= WR_DUTY;
            end
        end

        // Active copy: loaded only at frame boundaries, holds the already-effective duty
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                act_mode <= LED_OFF;
                act_duty <= '0;
            end else if (fb) begin
                act_mode <= new_mode;
                act_duty <= new_eff;
            end
        end

        // Logical drive for this channel at the current PWM position
        always_comb begin
            ch_on = 1'b0;
            case (act_mode)
                LED_ON:      ch_on = 1'b1;
                LED_PWM:     ch_on = (cnt < act_duty);
                LED_BREATHE: ch_on = (cnt < level);
                default:     ch_on = 1'b0;
            endcase
        end

        assign on[g] = ch_on;
    end

    // Pin register with board polarity folded in; reset leaves every LED dark
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            LED <= INV_MASK;
        end else begin
            LED <= on ^ INV_MASK;
        end
    end

endmodule

// File: tb/tb_led_pwm_bank.sv
`timescale 1ns/1ps
module tb_led_pwm_bank;
    import led_pkg::*;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       WR_EN = 1'b0;
    logic [2:0] WR_ADDR = 3'd0;
    logic [1:0] WR_MODE = 2'd0;
    logic [3:0] WR_DUTY = 4'd0;
    logic [6:0] LED;
    logic       FRAME_STB;
    logic [6:0] led3;
    logic       stb3;

    logic [6:0] inv_v = 7'b0000011;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    led_pwm_bank #(.N_CH(7), .PWM_BITS(4), .PRESCALE(1), .INV_MASK(7'b0000011)) dut (
        .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_MODE(WR_MODE),
        .WR_DUTY(WR_DUTY), .LED(LED), .FRAME_STB(FRAME_STB));

    led_pwm_bank #(.N_CH(7), .PWM_BITS(4), .PRESCALE(3), .INV_MASK(7'b0000011)) dut3 (
        .CLK(CLK), .RST(RST), .WR_EN(1'b0), .WR_ADDR(3'd0), .WR_MODE(2'd0),
        .WR_DUTY(4'd0), .LED(led3), .FRAME_STB(stb3));

    // Reference model: configuration as seen by software, frame index since reset
    logic [1:0] m_mode [7];
    logic [3:0] m_duty [7];
    int         g_f;
    int         last_f;
    logic [6:0] fled [16];
    logic [15:0] fstb;
    int         br_seq [$];

    typedef struct {
        logic [2:0] addr;
        logic [1:0] mode;
        logic [3:0] duty;
        int         on_lin;
        int         on_gam;
        logic       inv;
    } vec_t;
    vec_t tbl [8];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic int eff(input int v);
`ifdef LED_GAMMA_EN
        return (v * v) >> 4;
`else
        return v;
`endif
    endfunction

    // Triangle 0..15,15..0 with a 32-frame period
    function automatic int breathe_lvl(input int f);
        int p;
        p = f % 32;
        return (p < 16) ? p : 31 - p;
    endfunction

    function automatic int on_ticks(input logic [1:0] md, input logic [3:0] dt, input int f);
        case (md)
            LED_ON:      return 16;
            LED_PWM:     return eff(int'(dt));
            LED_BREATHE: return eff(breathe_lvl(f));
            default:     return 0;
        endcase
    endfunction

    function automatic int count_on(input int ch);
        int c;
        c = 0;
        for (int j = 0; j < 16; j++) begin
            if (fled[j][ch] != inv_v[ch]) c++;
        end
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 7; i++) begin
            m_mode[i] = LED_OFF;
            m_duty[i] = 4'd0;
        end
        g_f = 0;
    endtask

    // One PWM frame (16 cycles at PRESCALE=1): optional write at index wj, optional random writes,
    // then every channel's waveform is compared to the model's frame-level prediction.
    task automatic run_frame(input bit rnd, input int wj, input logic [2:0] wa,
                             input logic [1:0] wm, input logic [3:0] wd);
        logic [1:0]  amode [7];
        logic [3:0]  aduty [7];
        logic [15:0] exp_w;
        logic [15:0] act_w;
        int          n;
        amode = m_mode;
        aduty = m_duty;
        for (int j = 0; j < 16; j++) begin
            WR_EN = 1'b0;
            if (j == wj) begin
                WR_EN = 1'b1; WR_ADDR = wa; WR_MODE = wm; WR_DUTY = wd;
            end else if (rnd && $urandom_range(3) == 0) begin
                WR_EN   = 1'b1;
                WR_ADDR = 3'($urandom_range(7));
                WR_MODE = 2'($urandom_range(3));
                WR_DUTY = 4'($urandom_range(15));
            end
            if (WR_EN && WR_ADDR < 3'd7) begin
                m_mode[WR_ADDR] = WR_MODE;
                m_duty[WR_ADDR] = WR_DUTY;
            end
            @(posedge CLK);
            @(negedge CLK);
            fled[j] = LED;
            fstb[j] = FRAME_STB;
        end
        WR_EN = 1'b0;
        for (int i = 0; i < 7; i++) begin
            n = on_ticks(amode[i], aduty[i], g_f);
            for (int j = 0; j < 16; j++) begin
                exp_w[j] = (j < n) ^ inv_v[i];
                act_w[j] = fled[j][i];
            end
            check($sformatf("wave ch%0d frame%0d", i, g_f), 32'(act_w), 32'(exp_w));
        end
        check($sformatf("frame_stb frame%0d", g_f), 32'(fstb), 32'h8000);
        last_f = g_f;
        g_f++;
    endtask

    initial begin
        int k;
        int bad_led;
        logic [15:0] exp_w;
        logic [15:0] act_w;

        tbl[0] = '{3'd2, LED_PWM,     4'd4,  4,  1,  1'b0};
        tbl[1] = '{3'd2, LED_PWM,     4'd0,  0,  0,  1'b0};
        tbl[2] = '{3'd2, LED_PWM,     4'd15, 15, 14, 1'b0};
        tbl[3] = '{3'd0, LED_PWM,     4'd4,  4,  1,  1'b1};
        tbl[4] = '{3'd2, LED_PWM,     4'd8,  8,  4,  1'b0};
        tbl[5] = '{3'd5, LED_ON,      4'd9,  16, 16, 1'b0};
        tbl[6] = '{3'd5, LED_OFF,     4'd9,  0,  0,  1'b0};
        tbl[7] = '{3'd6, LED_PWM,     4'd12, 12, 9,  1'b0};

        for (int p = 0; p < 16; p++) br_seq.push_back(p);
        for (int p = 15; p >= 0; p--) br_seq.push_back(p);

        // Reset state
        model_reset();
        #22;
        check("reset led", 32'(LED), 32'h03);
        check("reset frame_stb", 32'(FRAME_STB), 0);
        check("reset led prescale3", 32'(led3), 32'h03);
        @(negedge CLK);
        RST = 1'b0;

        // Static ON on ch1 (active-low) and ch3 (active-high)
        run_frame(0, 3, 3'd1, LED_ON, 4'd0);
        run_frame(0, 3, 3'd3, LED_ON, 4'd0);
        run_frame(0, -1, 3'd0, LED_OFF, 4'd0);
        for (int j = 0; j < 16; j++) check($sformatf("static j%0d", j), 32'(fled[j]), 32'h09);

        // Table-driven single-channel settings, checked one frame after the write
        for (int v = 0; v < 8; v++) begin
            run_frame(0, 7, tbl[v].addr, tbl[v].mode, tbl[v].duty);
            run_frame(0, -1, 3'd0, LED_OFF, 4'd0);
            for (int j = 0; j < 16; j++) begin
`ifdef LED_GAMMA_EN
                exp_w[j] = (j < tbl[v].on_gam) ^ tbl[v].inv;
`else
                exp_w[j] = (j < tbl[v].on_lin) ^ tbl[v].inv;
`endif
                act_w[j] = fled[j][tbl[v].addr];
            end
            check($sformatf("table vec%0d", v), 32'(act_w), 32'(exp_w));
        end

        // Shadowing: mid-frame write waits, boundary-cycle write applies next frame, bad address ignored
        run_frame(0, 2, 3'd2, LED_PWM, 4'd4);
        run_frame(0, 5, 3'd2, LED_PWM, 4'd12);
        check("shadow keep old duty", count_on(2), eff(4));
        run_frame(0, 15, 3'd2, LED_PWM, 4'd7);
        check("shadow new duty", count_on(2), eff(12));
        run_frame(0, 4, 3'd7, LED_ON, 4'd0);
        check("fb-cycle write", count_on(2), eff(7));
        run_frame(0, -1, 3'd0, LED_OFF, 4'd0);
        check("addr7 ignored", count_on(2), eff(7));

        // Breathe on ch4 across more than one full period
        run_frame(0, 0, 3'd4, LED_BREATHE, 4'd0);
        for (int f = 0; f < 34; f++) begin
            run_frame(0, -1, 3'd0, LED_OFF, 4'd0);
            check($sformatf("breathe frame%0d", last_f), count_on(4), eff(br_seq[last_f % 32]));
        end

        // Randomized writes against the model
        for (int f = 0; f < 24; f++) run_frame(1, -1, 3'd0, LED_OFF, 4'd0);

        // Asynchronous reset mid-frame with ch2 ON
        run_frame(0, 0, 3'd2, LED_ON, 4'd0);
        run_frame(0, -1, 3'd0, LED_OFF, 4'd0);
        check("ch2 on before reset", 32'(LED[2]), 1);
        for (int j = 0; j < 5; j++) begin
            @(posedge CLK);
            @(negedge CLK);
        end
        #2 RST = 1'b1;
        #1;
        check("async reset led", 32'(LED), 32'h03);
        check("async reset frame_stb", 32'(FRAME_STB), 0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        k = 0;
        bad_led = 0;
        while (k < 100) begin
            @(posedge CLK);
            @(negedge CLK);
            k++;
            if (LED !== 7'b0000011) bad_led++;
            if (FRAME_STB === 1'b1) break;
        end
        check("first frame_stb after reset", k, 16);
        check("leds dark after reset", bad_led, 0);

        // PRESCALE=3 instance: 48-cycle frame period
        k = 0;
        while (k < 200 && stb3 !== 1'b1) begin
            @(posedge CLK);
            @(negedge CLK);
            k++;
        end
        check("prescale3 stb seen", 32'(stb3), 1);
        k = 0;
        bad_led = 0;
        do begin
            @(posedge CLK);
            @(negedge CLK);
            k++;
            if (led3 !== 7'b0000011) bad_led++;
        end while (k < 200 && stb3 !== 1'b1);
        check("prescale3 period", k, 48);
        check("prescale3 leds dark", bad_led, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
